// File: rtl/source_pump_sequencer.sv
// source_pump_sequencer: meters a requested number of peristaltic strokes into the
// Source inlet using a 3-valve pump. Each request primes, pumps, closes and settles.
// Optional feature macro: PUMP_REVERSE_EN (adds req_dir; reverse phase order, inlet closed).
module source_pump_sequencer #(
    parameter int unsigned PHASE_CYC     = 16,
    parameter int unsigned VOL_W         = 8,
    parameter int unsigned PRIME_STROKES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [VOL_W-1:0] req_vol,
`ifdef PUMP_REVERSE_EN
    input  logic             req_dir,
`endif
    output logic             req_ready,
    input  logic             abort,
    output logic [2:0]       valve,
    output logic             inlet_en,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [VOL_W-1:0] stroke_cnt
);

    localparam int unsigned TIMER_W   = $clog2(PHASE_CYC + 1);
    localparam int unsigned PRIME_W   = (PRIME_STROKES > 0) ? $clog2(PRIME_STROKES + 1) : 1;
    localparam int unsigned PRIME_MAX = (PRIME_STROKES > 0) ? (PRIME_STROKES - 1) : 0;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PHASE_CYC - 1);
    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(PRIME_MAX);
    localparam logic [2:0]         PH_FIRST   = 3'd0;
    localparam logic [2:0]         PH_LAST    = 3'd5;
    localparam logic [2:0]         VALVE_SHUT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_PUMP,
        S_HOLD,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         phase_q, phase_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [PRIME_W-1:0] prime_cnt_q, prime_cnt_d;
    logic [VOL_W-1:0]   vol_q, vol_d;
    logic               dir_q, dir_d;
    logic               aborted_q, aborted_d;
    logic [VOL_W-1:0]   stroke_cnt_q, stroke_cnt_d;
    logic [2:0]         valve_q, valve_d;
    logic               inlet_en_q, inlet_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               req_ready_q, req_ready_d;

    logic               req_dir_w;
    logic               accept;
    logic [2:0]         phase_next;
    logic               stroke_end;
    logic [VOL_W-1:0]   stroke_inc;

`ifdef PUMP_REVERSE_EN
    assign req_dir_w = req_dir;
`else
    assign req_dir_w = 1'b0;
`endif

    // Valve closure pattern for each pump phase (1 = closed, bit0 = inlet side).
    function automatic logic [2:0] phase_valve(input logic [2:0] ph);
        logic [2:0] v;
        case (ph)
            3'd0:    v = 3'b110;
            3'd1:    v = 3'b100;
            3'd2:    v = 3'b101;
            3'd3:    v = 3'b001;
            3'd4:    v = 3'b011;
            3'd5:    v = 3'b010;
            default: v = VALVE_SHUT;
        endcase
        return v;
    endfunction

    // Phase stepping and end-of-stroke detection; reverse flow walks P0,P5..P1.
    always_comb begin
        phase_next = PH_FIRST;
        stroke_end = 1'b0;
        if (dir_q) begin
            phase_next = (phase_q == PH_FIRST) ? PH_LAST : (phase_q - 3'd1);
            stroke_end = (timer_q == TIMER_LAST) && (phase_q == 3'd1);
        end else begin
            phase_next = (phase_q == PH_LAST) ? PH_FIRST : (phase_q + 3'd1);
            stroke_end = (timer_q == TIMER_LAST) && (phase_q == PH_LAST);
        end
        stroke_inc = stroke_cnt_q + VOL_W'(1);
        accept     = req_valid && req_ready_q;
    end

    // Next-state and next-output computation.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        timer_d      = timer_q;
        prime_cnt_d  = prime_cnt_q;
        vol_d        = vol_q;
        dir_d        = dir_q;
        aborted_d    = aborted_q;
        stroke_cnt_d = stroke_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    vol_d        = req_vol;
                    dir_d        = req_dir_w;
                    stroke_cnt_d = '0;
                    aborted_d    = 1'b0;
                    phase_d      = PH_FIRST;
                    timer_d      = '0;
                    prime_cnt_d  = '0;
                    if (PRIME_STROKES > 0) begin
                        state_d = S_PRIME;
                    end else if (req_vol != '0) begin
                        state_d = S_PUMP;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_PRIME, S_PUMP: begin
                if (abort) begin
                    // Partial stroke is dropped; stroke_cnt keeps completed strokes.
                    state_d   = S_HOLD;
                    timer_d   = '0;
                    aborted_d = 1'b1;
                end else if (timer_q != TIMER_LAST) begin
                    timer_d = timer_q + TIMER_W'(1);
                end else begin
                    timer_d = '0;
                    phase_d = phase_next;
                    if (stroke_end) begin
                        if (state_q == S_PRIME) begin
                            if (prime_cnt_q == PRIME_LAST) begin
                                prime_cnt_d = '0;
                                state_d     = (vol_q != '0) ? S_PUMP : S_HOLD;
                            end else begin
                                prime_cnt_d = prime_cnt_q + PRIME_W'(1);
                            end
                        end else begin
                            stroke_cnt_d = stroke_inc;
                            if (stroke_inc == vol_q) begin
                                state_d = S_HOLD;
                            end
                        end
                    end
                end
            end
            S_HOLD: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so derive them from the next state.
        valve_d     = VALVE_SHUT;
        inlet_en_d  = 1'b0;
        if ((state_d == S_PRIME) || (state_d == S_PUMP)) begin
            valve_d    = phase_valve(phase_d);
            inlet_en_d = ~dir_d;
        end
        busy_d      = (state_d != S_IDLE);
        req_ready_d = (state_d == S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            phase_q      <= PH_FIRST;
            timer_q      <= '0;
            prime_cnt_q  <= '0;
            vol_q        <= '0;
            dir_q        <= 1'b0;
            aborted_q    <= 1'b0;
            stroke_cnt_q <= '0;
            valve_q      <= VALVE_SHUT;
            inlet_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            timer_q      <= timer_d;
            prime_cnt_q  <= prime_cnt_d;
            vol_q        <= vol_d;
            dir_q        <= dir_d;
            aborted_q    <= aborted_d;
            stroke_cnt_q <= stroke_cnt_d;
            valve_q      <= valve_d;
            inlet_en_q   <= inlet_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign valve      = valve_q;
    assign inlet_en   = inlet_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign stroke_cnt = stroke_cnt_q;
    assign req_ready  = req_ready_q;

endmodule
